ans_sequencer: RTL

Job-level controller that sequences the `ans` core (loader, encoder, decoder) for a host.
- Accepts a job descriptor (mode and symbol count) and holds the core's `cmd` stable for the whole job, so the mode-gated core clocks never change mid-transfer.
- Streams input nibbles into the core and forwards core output nibbles to a sink.
- Detects end of output by an idle timeout and reports completion and the output count.
- Sits between the top-level pin logic and the `ans` instance.

---
 rtl/ans_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ans_sequencer.sv
// Job-level controller for the ans core: holds core_cmd steady for a whole job,
// passes input/output nibble streams through, and ends output on an idle timeout.
module ans_sequencer #(
  parameter int GAP_CYCLES   = 2,
  parameter int IDLE_TIMEOUT = 8,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_start,
  input  logic [1:0]       job_cmd,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_abort,
  output logic             job_busy,
  output logic             job_done,
  output logic             job_err,
  output logic [LEN_W-1:0] out_count,
  input  logic [3:0]       src_data,
  input  logic             src_vld,
  output logic             src_rdy,
  output logic [3:0]       snk_data,
  output logic             snk_vld,
  input  logic             snk_rdy,
  output logic [1:0]       core_cmd,
  output logic [3:0]       core_in,
  output logic             core_in_vld,
  input  logic             core_in_rdy,
  input  logic [3:0]       core_out,
  input  logic             core_out_vld,
  output logic             core_out_rdy,
  output logic [2:0]       state_dbg
);
  // Streams use valid/ready: a beat transfers on a rising edge where both are
  // high; valid never waits on ready. Both streams pass through with no delay.

  // Remaining count must hold 16 for load jobs even when LEN_W is narrow.
  localparam int REM_W  = (LEN_W > 5) ? LEN_W : 5;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_FEED     = 3'd2,
    S_DRAIN    = 3'd3,
    S_TEARDOWN = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [1:0]        mode;
  logic [REM_W-1:0]  rem;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              err_flag;
  logic              reject;
  logic              abort_hit;
  logic              in_hs;
  logic              out_hs;

  assign reject    = (job_cmd == 2'b00) || ((job_cmd != 2'b11) && (job_len == '0));
  assign abort_hit = job_abort && (state == S_SETUP || state == S_FEED || state == S_DRAIN);
  assign in_hs     = core_in_vld && core_in_rdy;
  assign out_hs    = snk_vld && snk_rdy;

  assign job_busy  = (state != S_IDLE);
  assign job_done  = (state == S_DONE);
  assign job_err   = (state == S_DONE) && err_flag;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    core_in      = 4'd0;
    core_in_vld  = 1'b0;
    src_rdy      = 1'b0;
    snk_data     = 4'd0;
    snk_vld      = 1'b0;
    core_out_rdy = 1'b0;
    // Load jobs produce no output, so the sink side stays closed for them.
    if ((state == S_FEED || state == S_DRAIN) && mode != 2'b11) begin
      snk_data     = core_out;
      snk_vld      = core_out_vld;
      core_out_rdy = snk_rdy;
    end
    case (state)
      S_IDLE: begin
        if (job_start) next_state = reject ? S_DONE : S_SETUP;
      end
      S_SETUP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) next_state = S_FEED;
      end
      S_FEED: begin
        core_in     = src_data;
        core_in_vld = src_vld;
        src_rdy     = core_in_rdy;
        if (src_vld && core_in_rdy && rem == REM_W'(1))
          next_state = (mode == 2'b11) ? S_TEARDOWN : S_DRAIN;
      end
      S_DRAIN: begin
        if (!core_out_vld && idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) next_state = S_TEARDOWN;
      end
      S_TEARDOWN: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort_hit) next_state = S_TEARDOWN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= 2'b00;
      rem       <= '0;
      gap_cnt   <= '0;
      idle_cnt  <= '0;
      err_flag  <= 1'b0;
      out_count <= '0;
      core_cmd  <= 2'b00;
    end else begin
      if (state != next_state)                           gap_cnt <= '0;
      else if (state == S_SETUP || state == S_TEARDOWN)  gap_cnt <= gap_cnt + GAP_W'(1);

      // Any cycle with output pending, stalled or not, restarts the idle window.
      if (state != S_DRAIN || core_out_vld) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + IDLE_W'(1);

      if (state == S_IDLE && job_start) begin
        mode     <= job_cmd;
        rem      <= (job_cmd == 2'b11) ? REM_W'(16) : REM_W'(job_len);
        err_flag <= reject;
        if (!reject) out_count <= '0;
      end

      if (state == S_FEED && in_hs) rem <= rem - REM_W'(1);
      if (out_hs && out_count != '1) out_count <= out_count + LEN_W'(1);
      if (abort_hit) err_flag <= 1'b1;

      // core_cmd moves only on SETUP entry and TEARDOWN entry.
      if (state == S_IDLE && next_state == S_SETUP)              core_cmd <= job_cmd;
      else if (state != S_TEARDOWN && next_state == S_TEARDOWN)  core_cmd <= 2'b00;
    end
  end
endmodule
